// File: rtl/uart_hex_rx_parser.sv
// uart_hex_rx_parser
//   Turns a stream of received ASCII hex characters into binary bytes. Two hex
//   digits, high nibble first, make one byte. A lone digit followed by a
//   separator becomes {4'h0, digit}. Assembled bytes are offered to a consumer
//   through a one-deep valid/ready output slot.
//
// Ports
//   clk          in   1  system clock
//   resetn       in   1  asynchronous, active-low reset
//   in_valid     in   1  one-cycle strobe, in_data valid
//   in_data      in   8  received ASCII character
//   out_valid    out  1  assembled byte available, held until accepted
//   out_ready    in   1  consumer accepts out_data when out_valid && out_ready
//   out_data     out  8  assembled byte
//   pending      out  1  high nibble stored, waiting for the second digit
//   err_char     out  1  one-cycle pulse, illegal character received
//   err_overrun  out  1  one-cycle pulse, completed byte dropped (slot full)
module uart_hex_rx_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       pending,
  output logic       err_char,
  output logic       err_overrun
);

  // A zero timeout disables the feature; keep a 1-bit counter so the vector stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, HAVE_HI} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_hi, w_hi_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_emit;
  logic [7:0]       w_emit_byte;
  logic             w_err_char_nxt;
  logic             w_slot_free;
  logic             w_is_hex, w_is_sep;
  logic [3:0]       w_nib;
  logic [5:0]       w_class;

  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_err_char;
  logic             r_err_overrun;

  // Returns {is_hex, is_sep, nibble}. For digits the low four ASCII bits are the
  // value; for both letter cases the low bits are 1..6, so adding 9 gives 10..15.
  function automatic logic [5:0] classify(input logic [7:0] c);
    logic       hex_digit, hex_upper, hex_lower, sep;
    logic [3:0] nib;
    hex_digit = (c >= 8'h30) && (c <= 8'h39);
    hex_upper = (c >= 8'h41) && (c <= 8'h46);
    hex_lower = (c >= 8'h61) && (c <= 8'h66);
    sep       = (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
    nib       = c[3:0] + ((hex_upper || hex_lower) ? 4'd9 : 4'd0);
    return {hex_digit || hex_upper || hex_lower, sep, nib};
  endfunction

  assign w_class  = classify(in_data);
  assign w_is_hex = w_class[5];
  assign w_is_sep = w_class[4];
  assign w_nib    = w_class[3:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_hi_nxt       = r_hi;
    w_cnt_nxt      = r_cnt;
    w_emit         = 1'b0;
    w_emit_byte    = 8'h00;
    w_err_char_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_is_hex) begin
            w_hi_nxt    = w_nib;
            w_cnt_nxt   = '0;
            w_state_nxt = HAVE_HI;
          end else if (!w_is_sep) begin
            w_err_char_nxt = 1'b1;
          end
        end
      end
      HAVE_HI: begin
        // A character arriving on the timeout cycle still completes the byte.
        if (in_valid) begin
          w_state_nxt = IDLE;
          if (w_is_hex) begin
            w_emit      = 1'b1;
            w_emit_byte = {r_hi, w_nib};
          end else if (w_is_sep) begin
            w_emit      = 1'b1;
            w_emit_byte = {4'h0, r_hi};
          end else begin
            w_err_char_nxt = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The slot can take a new byte if it is empty or being drained this cycle.
  assign w_slot_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_hi          <= 4'h0;
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= 8'h00;
      r_err_char    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hi          <= w_hi_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err_char    <= w_err_char_nxt;
      r_err_overrun <= w_emit && !w_slot_free;
      if (w_emit && w_slot_free) begin
        r_out_data  <= w_emit_byte;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign pending     = (r_state == HAVE_HI);
  assign err_char    = r_err_char;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_uart_hex_rx_parser.sv
// Testbench for uart_hex_rx_parser: directed scenarios followed by random
// character traffic with random consumer back-pressure. A reference model
// predicts bytes (queued) and per-cycle flags; a monitor pops and compares.
module tb_uart_hex_rx_parser;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       pending;
  logic       err_char;
  logic       err_overrun;

  always #5 clk = ~clk;

  uart_hex_rx_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pending(pending), .err_char(err_char), .err_overrun(err_overrun)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = hex digit, 1 = separator, 2 = illegal
  function automatic int char_kind(input logic [7:0] c, output logic [3:0] v);
    v = 4'h0;
    if (c >= "0" && c <= "9") begin v = 4'(c - "0"); return 0; end
    if (c >= "A" && c <= "F") begin v = 4'(c - "A" + 10); return 0; end
    if (c >= "a" && c <= "f") begin v = 4'(c - "a" + 10); return 0; end
    if (c == " " || c == 8'h0D || c == 8'h0A || c == ",") return 1;
    return 2;
  endfunction

  // Reference model: a held high nibble with its waiting time, and whether the
  // output slot is occupied.
  bit         m_have;
  logic [3:0] m_hi;
  int         m_age;
  bit         m_ov;
  bit         m_errc, m_erro;
  bit         m_emit;
  logic [7:0] m_byte;
  logic [3:0] m_v;
  int         m_k;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_have = 0; m_age = 0; m_ov = 0; m_errc = 0; m_erro = 0;
      exp_q.delete();
    end else begin
      m_emit = 0; m_errc = 0; m_erro = 0; m_byte = 8'h00;
      if (in_valid) begin
        m_k = char_kind(in_data, m_v);
        if (m_k == 0) begin
          if (m_have) begin m_emit = 1; m_byte = {m_hi, m_v}; m_have = 0; end
          else begin m_have = 1; m_hi = m_v; m_age = 0; end
        end else if (m_k == 1) begin
          if (m_have) begin m_emit = 1; m_byte = {4'h0, m_hi}; m_have = 0; end
        end else begin
          m_errc = 1; m_have = 0;
        end
      end else if (m_have) begin
        m_age++;
        if (m_age == TO) m_have = 0;
      end
      if (m_emit) begin
        if (!m_ov || out_ready) begin exp_q.push_back(m_byte); m_ov = 1; end
        else m_erro = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  // Monitor: flags every cycle, data on every handshake.
  always @(negedge clk) begin
    if (resetn) begin
      chk("out_valid", out_valid, m_ov);
      chk("pending", pending, m_have);
      chk("err_char", err_char, m_errc);
      chk("err_overrun", err_overrun, m_erro);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", out_data, 32'hFFFF_FFFF);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] c, input logic r);
    @(posedge clk);
    #3;
    in_valid = v; in_data = c; out_ready = r;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, out_ready);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, out_ready);
  endtask

  function automatic logic [7:0] pick_char();
    int k;
    logic [7:0] h;
    k = $urandom_range(0, 9);
    h = 8'($urandom_range(0, 5));
    case (k)
      0, 1, 2, 3: return 8'("0" + $urandom_range(0, 9));
      4, 5:       return "a" + h;
      6:          return "A" + h;
      7: begin
        case ($urandom_range(0, 3))
          0: return " ";
          1: return 8'h0D;
          2: return 8'h0A;
          default: return ",";
        endcase
      end
      default:    return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic rdy;
    int   r;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err_char", err_char, 0);
    chk("rst_err_overrun", err_overrun, 0);
    @(posedge clk); #3; resetn = 1'b1;
    idle(2);

    // Pairs, lone digit, separators
    send("4"); send("1"); idle(2);
    send("a"); send("B"); idle(2);
    send("f"); send("F"); send(" "); idle(2);
    send("7"); send(8'h0D); idle(2);
    send(8'h0A); idle(2);
    // Illegal character mid-byte
    send("3"); send("G"); idle(2);
    send("3"); send("4"); idle(2);
    // Back-pressure and overrun
    step(1'b0, 8'h00, 1'b0);
    send("1"); send("2"); send("3"); send("4"); idle(3);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 1'b1);
    // Timeout of a lone high nibble
    send("5"); idle(TO + 5);
    send("6"); send("7"); idle(2);
    // Nibble arriving exactly on the timeout cycle
    send("c"); idle(TO - 1); send("d"); idle(2);
    // Reset while holding a byte and a pending nibble
    step(1'b0, 8'h00, 1'b0);
    send("1"); send("2"); send("9");
    step(1'b0, 8'h00, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_err_char", err_char, 0);
    chk("mid_rst_err_overrun", err_overrun, 0);
    repeat (2) @(posedge clk);
    #3; resetn = 1'b1; out_ready = 1'b1;
    send("8"); send("9"); idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 2) begin
        repeat ($urandom_range(TO - 10, TO + 10)) step(1'b0, 8'h00, rdy);
      end else if (r < 45) begin
        step(1'b0, 8'h00, rdy);
      end else begin
        step(1'b1, pick_char(), rdy);
      end
    end

    // Drain and confirm every predicted byte was delivered
    step(1'b0, 8'h00, 1'b1);
    idle(5);
    chk("bytes_outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
